bitcnt_rr_sched: RTL and testbench
==================================

Name: bitcnt_rr_sched

Overview:
Round-robin scheduler that shares one bit-1 counter engine between N requesters. Each requester presents an 8-bit word and a request. The scheduler grants one requester at a time and launches the engine with a single-cycle load. It then waits for completion and returns the count tagged with the requester ID. It sits between the requesters and the engine instance, and adds a hang timeout so a stuck engine cannot block the bus.

Parameters:
N, 4, number of requesters (2..8)
DW, 8, data word width
CW, 4, count width, equal to $clog2(DW+1)
IW, 2, requester ID width, equal to $clog2(N)
TIMEOUT, 32, maximum number of WAIT cycles before the job is aborted

Ports:
iclk  in  1  clock
irst  in  1  reset, synchronous, active-high
i_req  in  N  per-requester request; held high until the matching o_gnt bit is seen
i_data  in  N*DW  packed request data; requester k occupies [k*DW +: DW]
o_gnt  out  N  one-hot, 1-cycle pulse: requester's data accepted
o_eng_load  out  1  engine load strobe, 1 cycle
o_eng_data  out  DW  engine data, valid while o_eng_load is high
i_eng_ready  in  1  engine idle / result valid
i_eng_cnt  in  CW  engine count result
o_done  out  1  1-cycle result strobe
o_done_id  out  IW  requester ID of the result
o_done_cnt  out  CW  count result; 0 on timeout
o_done_err  out  1  job aborted by timeout
o_busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, iclk. Reset irst is synchronous and active-high.
- Reset values, taking effect at the first edge with irst=1:
  - state IDLE, pointer ptr=0, timer=0, busy_seen=0.
  - All outputs 0.
  - Captured data and ID registers = 0.
- States and transitions:
  - IDLE:
    - If i_eng_ready=1 and |i_req, pick the first requester with its request high, scanning ptr, ptr+1, ... mod N.
    - Register the picked ID and its i_data slice, then go to ISSUE.
    - If i_eng_ready=0, no pick is made and the state stays IDLE.
  - ISSUE (exactly 1 cycle):
    - o_eng_load=1, o_eng_data=captured data, o_gnt[id]=1.
    - Clear timer and busy_seen, then go to WAIT.
  - WAIT:
    - timer increments every cycle.
    - busy_seen is set when i_eng_ready=0 is sampled.
    - If busy_seen=1 and i_eng_ready=1: capture i_eng_cnt, set err=0, go to RESP.
    - Else if timer reaches TIMEOUT: set cnt=0, err=1, go to RESP.
    - Completion takes priority over timeout when both hold in the same cycle.
  - RESP (exactly 1 cycle):
    - o_done=1 with o_done_id, o_done_cnt and o_done_err valid.
    - ptr is updated to (id+1) mod N, then go to IDLE.
- Latency:
  - Request sampled in IDLE at edge t; o_gnt and o_eng_load are high in cycle t+1.
  - o_done is high 1 cycle after the WAIT exit condition is sampled.
  - Minimum job period is 4 cycles plus the engine busy time.
- Requester rules:
  - A requester drops i_req the cycle after it sees its o_gnt bit.
  - A request still high in the following IDLE cycle is treated as a new job.
  - i_data changes while not granted are harmless; data is sampled only on the IDLE pick edge.
- Boundary conditions:
  - Simultaneous requests: round-robin order from ptr, with no starvation. Worst-case wait is N-1 jobs.
  - ptr wraps from N-1 to 0.
  - An engine that never deasserts ready, or never reasserts it, produces err=1 after exactly TIMEOUT WAIT cycles. Scheduling then resumes normally.
  - irst during any state aborts the job with no o_done. Outputs are 0 the cycle after, and ptr=0.
  - i_req bits at index ≥ N do not exist; requests on unused ID encodings are never generated.
  - o_eng_load is never high outside ISSUE.

Decomposition:
- Shared package bitcnt_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - DW default;
  - the CW/IW width helper function.
- One combinational sub-module, rr_pick (inputs req[N] and ptr; outputs valid and id), is natural and reusable by other arbiters.
- The top holds the FSM, the timer and the capture registers.

Test Plan:
- Bench engine model: ready drops 1 cycle after load and returns DW cycles later with popcount.
- Scenario 1: after reset, i_req=4'b0001, data0=8'h5F → o_gnt=4'b0001 for 1 cycle; o_eng_load for 1 cycle with 8'h5F; o_done id=0, cnt=6, err=0. o_busy is low before the pick and after RESP.
- Scenario 2: i_req=4'b1111 held, data 8'hEE/8'hF2/8'hCC/8'h00 → grants in order 0,1,2,3; results cnt 6,5,4,0 with matching IDs; ptr ends at 0.
- Scenario 3: i_req=4'b1010 continuously re-raised → grants alternate 1,3,1,3 over 8 jobs, never two consecutive to the same requester.
- Scenario 4: engine model with ready stuck high, TIMEOUT=32 → o_done in the 33rd cycle after load with err=1, cnt=0. A following req2 job completes normally with err=0.
- Scenario 5: i_eng_ready=0 in IDLE with i_req=4'b0001 → no o_gnt or load; 1 cycle after ready rises, o_gnt=4'b0001.
- Scenario 6: irst=1 for 1 cycle during WAIT of a req0 job → no o_done; all outputs 0; next req2 is granted first (ptr=0 scan finds 2) and completes correctly.

Source files
------------

// File: rtl/bitcnt_pkg.sv
// Shared encodings and width helpers for the bit-count round-robin scheduler.
package bitcnt_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int DW_DEF = 8;

  // Bits needed to encode n distinct values, never less than one.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from ptr upward, mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] id_o
);

  // Scan farthest-first so the request nearest to ptr overwrites the result last.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        valid_o = 1'b1;
        id_o    = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bitcnt_rr_sched.sv
// Shares one bit-count engine among N requesters: round-robin pick, one-cycle load,
// wait for completion with a hang timeout, then return the count tagged with the ID.
module bitcnt_rr_sched
  import bitcnt_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = DW_DEF,
  parameter int CW      = width_of(DW + 1),
  parameter int IW      = width_of(N),
  parameter int TIMEOUT = 32
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [N-1:0]  i_req,
  input  logic [N*DW-1:0] i_data,
  output logic [N-1:0]  o_gnt,
  output logic          o_eng_load,
  output logic [DW-1:0] o_eng_data,
  input  logic          i_eng_ready,
  input  logic [CW-1:0] i_eng_cnt,
  output logic          o_done,
  output logic [IW-1:0] o_done_id,
  output logic [CW-1:0] o_done_cnt,
  output logic          o_done_err,
  output logic          o_busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_seen_q, busy_seen_d;
  logic [IW-1:0] id_q, id_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          pick_vld;
  logic [IW-1:0] pick_id;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    busy_seen_d = busy_seen_q;
    id_d        = id_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_eng_ready && pick_vld) begin
          id_d    = pick_id;
          data_d  = i_data[int'(pick_id)*DW +: DW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d     = '0;
        busy_seen_d = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (!i_eng_ready) busy_seen_d = 1'b1;
        // Completion wins over timeout when both land on the same edge.
        if (busy_seen_q && i_eng_ready) begin
          cnt_d   = i_eng_cnt;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      busy_seen_q <= 1'b0;
      id_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      busy_seen_q <= busy_seen_d;
      id_q        <= id_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode from state so they are all zero whenever the FSM sits in IDLE.
  assign o_busy     = (state_q != S_IDLE);
  assign o_eng_load = (state_q == S_ISSUE);
  assign o_eng_data = o_eng_load ? data_q : '0;
  assign o_gnt      = o_eng_load ? (N'(1) << id_q) : '0;
  assign o_done     = (state_q == S_RESP);
  assign o_done_id  = o_done ? id_q : '0;
  assign o_done_cnt = o_done ? cnt_q : '0;
  assign o_done_err = o_done ? err_q : 1'b0;

endmodule

// File: tb/tb_bitcnt_rr_sched.sv
// Directed bench for bitcnt_rr_sched with a behavioural bit-count engine model.
module tb_bitcnt_rr_sched;

  localparam int N = 4, DW = 8, CW = 4, IW = 2;

  logic            iclk = 1'b0;
  logic            irst;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    o_gnt;
  logic            o_eng_load;
  logic [DW-1:0]   o_eng_data;
  logic            i_eng_ready;
  logic [CW-1:0]   i_eng_cnt;
  logic            o_done;
  logic [IW-1:0]   o_done_id;
  logic [CW-1:0]   o_done_cnt;
  logic            o_done_err;
  logic            o_busy;

  bitcnt_rr_sched #(.N(N), .DW(DW), .TIMEOUT(32)) dut (
    .iclk(iclk), .irst(irst), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_eng_load(o_eng_load), .o_eng_data(o_eng_data),
    .i_eng_ready(i_eng_ready), .i_eng_cnt(i_eng_cnt),
    .o_done(o_done), .o_done_id(o_done_id), .o_done_cnt(o_done_cnt),
    .o_done_err(o_done_err), .o_busy(o_busy)
  );

  always #5 iclk = ~iclk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Engine model: ready drops the cycle after load and returns DW cycles later.
  logic          rdy_en, stuck;
  logic          mdl_rdy;
  logic [CW-1:0] mdl_cnt;
  int            bcnt;

  always @(posedge iclk) begin
    cyc <= cyc + 1;
    if (irst) begin
      mdl_rdy <= 1'b1; bcnt <= 0; mdl_cnt <= '0;
    end else if (stuck) begin
      mdl_rdy <= 1'b1;
    end else if (o_eng_load) begin
      mdl_rdy <= 1'b0; bcnt <= DW; mdl_cnt <= CW'($countones(o_eng_data));
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) mdl_rdy <= 1'b1;
    end
  end

  assign i_eng_ready = rdy_en & mdl_rdy;
  assign i_eng_cnt   = mdl_cnt;

  logic [N-1:0]  gnt_log[$];
  logic [DW-1:0] ld_data[$];
  int            ld_cyc[$];
  logic [IW-1:0] done_id[$];
  logic [CW-1:0] done_cnt[$];
  logic          done_err[$];
  int            done_cyc[$];

  always @(negedge iclk) begin
    if (!irst) begin
      if (o_gnt != '0 || o_eng_load) begin
        chk("load_with_gnt", int'(o_eng_load), 1);
        chk("gnt_onehot", $countones(o_gnt), 1);
        gnt_log.push_back(o_gnt);
        ld_data.push_back(o_eng_data);
        ld_cyc.push_back(cyc);
      end
      if (o_done) begin
        done_id.push_back(o_done_id);
        done_cnt.push_back(o_done_cnt);
        done_err.push_back(o_done_err);
        done_cyc.push_back(cyc);
      end
    end
  end

  function automatic int outs_or();
    return int'({o_gnt, o_eng_load, o_eng_data, o_done, o_done_id, o_done_cnt, o_done_err, o_busy});
  endfunction

  task automatic do_reset();
    @(negedge iclk);
    irst = 1'b1; i_req = '0;
    repeat (2) @(negedge iclk);
    irst = 1'b0;
  endtask

  // Drop each granted request unless sticky; stop all requests after ngnt grants.
  task automatic run(input int ngnt, input logic [N-1:0] sticky, input int budget);
    int d0, g, i;
    d0 = done_id.size(); g = 0; i = 0;
    while ((done_id.size() - d0 < ngnt) && i < budget) begin
      @(negedge iclk); i++;
      if (o_gnt != '0) begin
        g++;
        if (g >= ngnt) i_req = '0;
        else i_req = i_req & ~(o_gnt & ~sticky);
      end
    end
    chk("run_budget", int'(done_id.size() - d0 >= ngnt), 1);
  endtask

  int g0, d0, c0;
  logic [N-1:0]  exp_g3[8] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic [CW-1:0] exp_c2[4] = '{4'd6, 4'd5, 4'd4, 4'd0};

  initial begin
    irst = 1'b1; i_req = '0; i_data = '0; rdy_en = 1'b1; stuck = 1'b0;
    repeat (3) @(negedge iclk);
    chk("rst_outputs", outs_or(), 0);
    irst = 1'b0;

    // S1: single request
    @(negedge iclk);
    chk("s1_busy_pre", int'(o_busy), 0);
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data[0*DW +: DW] = 8'h5F; i_req = 4'b0001;
    run(1, '0, 100);
    @(negedge iclk);
    chk("s1_busy_post", int'(o_busy), 0);
    chk("s1_ngnt", gnt_log.size() - g0, 1);
    chk("s1_gnt", int'(gnt_log[g0]), 4'b0001);
    chk("s1_ld_data", int'(ld_data[g0]), 8'h5F);
    chk("s1_id", int'(done_id[d0]), 0);
    chk("s1_cnt", int'(done_cnt[d0]), 6);
    chk("s1_err", int'(done_err[d0]), 0);
    chk("s1_latency", done_cyc[d0] - ld_cyc[g0], 10);

    // S2: all four request after reset (ptr was 1, must restart at 0)
    do_reset();
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data = {8'h00, 8'hCC, 8'hF2, 8'hEE}; i_req = 4'b1111;
    run(4, '0, 200);
    chk("s2_ngnt", gnt_log.size() - g0, 4);
    for (int k = 0; k < 4; k++) begin
      chk("s2_gnt", int'(gnt_log[g0+k]), 1 << k);
      chk("s2_id", int'(done_id[d0+k]), k);
      chk("s2_cnt", int'(done_cnt[d0+k]), int'(exp_c2[k]));
    end

    // S3: requesters 1 and 3 keep re-raising; ptr wrapped to 0
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data = {8'hFF, 8'h00, 8'h0F, 8'h00}; i_req = 4'b1010;
    run(8, 4'b1010, 400);
    chk("s3_ngnt", gnt_log.size() - g0, 8);
    for (int k = 0; k < 8; k++) begin
      chk("s3_gnt", int'(gnt_log[g0+k]), int'(exp_g3[k]));
      chk("s3_cnt", int'(done_cnt[d0+k]), (k % 2 == 0) ? 4 : 8);
    end

    // S4: stuck-ready engine times out, then a normal job
    stuck = 1'b1;
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data = {8'h00, 8'h81, 8'h00, 8'hAA}; i_req = 4'b0001;
    run(1, '0, 100);
    chk("s4_to_id", int'(done_id[d0]), 0);
    chk("s4_to_err", int'(done_err[d0]), 1);
    chk("s4_to_cnt", int'(done_cnt[d0]), 0);
    chk("s4_to_latency", done_cyc[d0] - ld_cyc[g0], 33);
    stuck = 1'b0;
    i_req = 4'b0100;
    run(1, '0, 100);
    chk("s4_ok_id", int'(done_id[d0+1]), 2);
    chk("s4_ok_err", int'(done_err[d0+1]), 0);
    chk("s4_ok_cnt", int'(done_cnt[d0+1]), 2);

    // S5: engine not ready holds off the pick
    @(negedge iclk);
    rdy_en = 1'b0;
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data[0*DW +: DW] = 8'h5F; i_req = 4'b0001;
    repeat (6) @(negedge iclk);
    chk("s5_no_gnt", gnt_log.size() - g0, 0);
    c0 = cyc; rdy_en = 1'b1;
    run(1, '0, 100);
    chk("s5_gnt", int'(gnt_log[g0]), 4'b0001);
    chk("s5_gnt_cycle", ld_cyc[g0], c0 + 1);
    chk("s5_cnt", int'(done_cnt[d0]), 6);

    // S6: reset mid-WAIT aborts the job silently
    g0 = gnt_log.size(); d0 = done_id.size();
    i_data[0*DW +: DW] = 8'h3C; i_req = 4'b0001;
    for (int i = 0; i < 50 && o_gnt == '0; i++) @(negedge iclk);
    chk("s6_gnt_seen", int'(o_gnt), 4'b0001);
    i_req = '0;
    repeat (3) @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    chk("s6_rst_outputs", outs_or(), 0);
    repeat (20) @(negedge iclk);
    chk("s6_no_done", done_id.size() - d0, 0);
    g0 = gnt_log.size();
    i_data[2*DW +: DW] = 8'h7E; i_req = 4'b0100;
    run(1, '0, 100);
    chk("s6_gnt", int'(gnt_log[g0]), 4'b0100);
    chk("s6_id", int'(done_id[d0]), 2);
    chk("s6_cnt", int'(done_cnt[d0]), 6);
    chk("s6_err", int'(done_err[d0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
